// File: rtl/trap_irq_ctrl_pkg.sv
// Shared encodings for trap_irq_ctrl: FSM states, CSR addresses, mstatus/mip
// bit positions and interrupt cause codes.
package trap_irq_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RUN        = 3'd1;
  localparam logic [2:0] ST_IRQ_DRAIN  = 3'd2;
  localparam logic [2:0] ST_IRQ_HANDLE = 3'd3;
  localparam logic [2:0] ST_FLUSH      = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam int MIP_MSIP_BIT  = 3;
  localparam int MIP_MTIP_BIT  = 7;
  localparam int MIP_MEIP_BIT  = 11;
  localparam int MIP_PLAT_BASE = 16;

  localparam int         CAUSE_W   = 5;
  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

endpackage

// File: rtl/trap_irq_ctrl_arb.sv
// irq_prio_arb: combinational fixed-priority encoder over pending interrupts.
// Order: external > software > timer > plat[0] > ... > plat[N-1].
module irq_prio_arb
  import trap_irq_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int NUM_PLAT_IRQ = 4
) (
  input  logic [XLEN-1:0]    pending,
  output logic               valid,
  output logic [CAUSE_W-1:0] code
);

  logic unused_pending;
  assign unused_pending = ^pending;

  // Lowest-priority sources are evaluated first so higher ones overwrite.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (pending[MIP_PLAT_BASE + i]) begin
        valid = 1'b1;
        code  = CAUSE_W'(MIP_PLAT_BASE + i);
      end
    end
    if (pending[MIP_MTIP_BIT]) begin
      valid = 1'b1;
      code  = CAUSE_MTI;
    end
    if (pending[MIP_MSIP_BIT]) begin
      valid = 1'b1;
      code  = CAUSE_MSI;
    end
    if (pending[MIP_MEIP_BIT]) begin
      valid = 1'b1;
      code  = CAUSE_MEI;
    end
  end

endmodule

// File: rtl/trap_irq_ctrl.sv
// Machine-mode trap CSRs, interrupt arbitration and pipeline run-control FSM.
// Optional macro TRAP_VECTORED_MODE_EN enables vectored mtvec (mode 1).
//
// state         | meaning
// IDLE          | waiting for start_program
// RUN           | program executing, interrupts may be taken
// IRQ_DRAIN     | irq_prep raised, waiting for pipeline drain
// IRQ_HANDLE    | in trap handler, waiting for MRET
// FLUSH         | flush_o raised, CSRs reset, waiting for all_ready
// DONE          | program finished
module trap_irq_ctrl
  import trap_irq_ctrl_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              NUM_PLAT_IRQ = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [XLEN-1:0]         control_signal,
  input  logic                    end_condition,
  input  logic                    all_ready,
  input  logic                    ready_for_irq_handler,
  input  logic                    mret_inst,
  input  logic [XLEN-1:0]         resume_pc,
  input  logic                    timer_timeout,
  input  logic                    sw_irq,
  input  logic                    ext_irq,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
  input  logic                    write_csr,
  input  logic [11:0]             csr_wr_addr,
  input  logic [XLEN-1:0]         csr_wr_data,
  input  logic [11:0]             csr_rd_addr,
  output logic [XLEN-1:0]         csr_rd_data,
  output logic                    flush_o,
  output logic                    enable_design,
  output logic                    irq_prep,
  output logic [XLEN-1:0]         trap_vector,
  output logic [XLEN-1:0]         mepc_o,
  output logic                    program_finished
);

`ifdef TRAP_VECTORED_MODE_EN
  localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RESET;
`else
  localparam logic [XLEN-1:0] MTVEC_INIT = {MTVEC_RESET[XLEN-1:2], 2'b00};
`endif

  logic [2:0]         state_q, state_d;
  logic [XLEN-1:0]    mip_q, mip_next, irq_mask, pending;
  logic [XLEN-1:0]    mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtvec_wr;
  logic               mstatus_mie_q, mstatus_mpie_q;
  logic [CAUSE_W-1:0] cause_q, arb_code;
  logic               arb_valid, take_irq, reset_req, start_req;
  logic               irq_latch, trap_entry, mret_ret, csr_clear;
  logic               unused_inputs;

  assign unused_inputs = ^{control_signal[XLEN-1:2], resume_pc[1:0]};
  assign reset_req     = control_signal[1];
  assign start_req     = control_signal[0];

  always_comb begin
    mip_next = '0;
    irq_mask = '0;
    mip_next[MIP_MEIP_BIT] = ext_irq;
    mip_next[MIP_MSIP_BIT] = sw_irq;
    mip_next[MIP_MTIP_BIT] = timer_timeout;
    irq_mask[MIP_MEIP_BIT] = 1'b1;
    irq_mask[MIP_MSIP_BIT] = 1'b1;
    irq_mask[MIP_MTIP_BIT] = 1'b1;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      mip_next[MIP_PLAT_BASE + i] = plat_irq[i];
      irq_mask[MIP_PLAT_BASE + i] = 1'b1;
    end
  end

  assign pending = mip_q & mie_q;

  irq_prio_arb #(
    .XLEN         (XLEN),
    .NUM_PLAT_IRQ (NUM_PLAT_IRQ)
  ) u_arb (
    .pending (pending),
    .valid   (arb_valid),
    .code    (arb_code)
  );

  assign take_irq = (state_q == ST_RUN) && mstatus_mie_q && arb_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (reset_req) state_d = ST_FLUSH;
                     else if (start_req) state_d = ST_RUN;
      ST_RUN:        if (reset_req) state_d = ST_FLUSH;
                     else if (take_irq) state_d = ST_IRQ_DRAIN;
                     else if (end_condition) state_d = ST_DONE;
      ST_IRQ_DRAIN:  if (reset_req) state_d = ST_FLUSH;
                     else if (ready_for_irq_handler) state_d = ST_IRQ_HANDLE;
      ST_IRQ_HANDLE: if (reset_req) state_d = ST_FLUSH;
                     else if (mret_inst) state_d = ST_RUN;
      ST_FLUSH:      if (!reset_req && all_ready) state_d = ST_IDLE;
      ST_DONE:       if (reset_req) state_d = ST_FLUSH;
      default:       state_d = ST_IDLE;
    endcase
  end

  assign irq_latch  = (state_q == ST_RUN) && (state_d == ST_IRQ_DRAIN);
  assign trap_entry = (state_q == ST_IRQ_DRAIN) && (state_d == ST_IRQ_HANDLE);
  assign mret_ret   = (state_q == ST_IRQ_HANDLE) && (state_d == ST_RUN);
  assign csr_clear  = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

`ifdef TRAP_VECTORED_MODE_EN
  assign mtvec_wr = csr_wr_data;
`else
  assign mtvec_wr = {csr_wr_data[XLEN-1:2], 2'b00};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      mip_q          <= '0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_INIT;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      cause_q        <= '0;
    end else begin
      state_q <= state_d;
      mip_q   <= mip_next;
      if (irq_latch) cause_q <= arb_code;
      if (csr_clear) begin
        mip_q          <= '0;
        mie_q          <= '0;
        mtvec_q        <= MTVEC_INIT;
        mscratch_q     <= '0;
        mepc_q         <= '0;
        mcause_q       <= '0;
        mstatus_mie_q  <= 1'b0;
        mstatus_mpie_q <= 1'b0;
        cause_q        <= '0;
      end else begin
        if (write_csr) begin
          case (csr_wr_addr)
            CSR_MSTATUS: begin
              mstatus_mie_q  <= csr_wr_data[MSTATUS_MIE_BIT];
              mstatus_mpie_q <= csr_wr_data[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      mie_q      <= csr_wr_data & irq_mask;
            CSR_MTVEC:    mtvec_q    <= mtvec_wr;
            CSR_MSCRATCH: mscratch_q <= csr_wr_data;
            CSR_MEPC:     mepc_q     <= {csr_wr_data[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_q   <= csr_wr_data;
            default: ;
          endcase
        end
        // Hardware trap/return updates come last so they win over CSR writes.
        if (trap_entry) begin
          mepc_q         <= {resume_pc[XLEN-1:2], 2'b00};
          mcause_q       <= {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
          mstatus_mpie_q <= mstatus_mie_q;
          mstatus_mie_q  <= 1'b0;
        end else if (mret_ret) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    csr_rd_data = '0;
    case (csr_rd_addr)
      CSR_MSTATUS: begin
        csr_rd_data[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        csr_rd_data[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
      end
      CSR_MIE:      csr_rd_data = mie_q;
      CSR_MTVEC:    csr_rd_data = mtvec_q;
      CSR_MSCRATCH: csr_rd_data = mscratch_q;
      CSR_MEPC:     csr_rd_data = mepc_q;
      CSR_MCAUSE:   csr_rd_data = mcause_q;
      CSR_MIP:      csr_rd_data = mip_q;
      default: ;
    endcase
    if (write_csr && (csr_wr_addr == csr_rd_addr) && (csr_rd_addr != CSR_MIP))
      csr_rd_data = csr_wr_data;
  end

`ifdef TRAP_VECTORED_MODE_EN
  always_comb begin
    trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) &&
        ((state_q == ST_IRQ_DRAIN) || (state_q == ST_IRQ_HANDLE)))
      trap_vector = {mtvec_q[XLEN-1:2], 2'b00} +
                    {{(XLEN-CAUSE_W-2){1'b0}}, cause_q, 2'b00};
  end
`else
  assign trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
`endif

  assign flush_o          = (state_q == ST_FLUSH);
  assign enable_design    = (state_q != ST_IDLE);
  assign irq_prep         = (state_q == ST_IRQ_DRAIN);
  assign program_finished = (state_q == ST_DONE);
  assign mepc_o           = mepc_q;

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// Self-checking bench for trap_irq_ctrl: directed scenarios followed by
// randomized interrupt patterns checked against a priority-list model.
module tb_trap_irq_ctrl;

  localparam int          XLEN    = 32;
  localparam int          NP      = 4;
  localparam logic [31:0] MTV_RST = 32'h0000_0204;

  logic              clk = 1'b0;
  logic              reset;
  logic [XLEN-1:0]   control_signal;
  logic              end_condition, all_ready, ready_for_irq_handler, mret_inst;
  logic [XLEN-1:0]   resume_pc;
  logic              timer_timeout, sw_irq, ext_irq;
  logic [NP-1:0]     plat_irq;
  logic              write_csr;
  logic [11:0]       csr_wr_addr, csr_rd_addr;
  logic [XLEN-1:0]   csr_wr_data, csr_rd_data;
  logic              flush_o, enable_design, irq_prep, program_finished;
  logic [XLEN-1:0]   trap_vector, mepc_o;

  int n_cmp = 0;
  int n_err = 0;
  int prep_cnt, wait_cnt, win;
  logic [31:0] mie_v, pend_v, pc_v, exp_mtvec, exp_tv;
  logic e_v, s_v, t_v;
  logic [NP-1:0] p_v;

  trap_irq_ctrl #(
    .XLEN         (XLEN),
    .NUM_PLAT_IRQ (NP),
    .MTVEC_RESET  (MTV_RST)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .control_signal        (control_signal),
    .end_condition         (end_condition),
    .all_ready             (all_ready),
    .ready_for_irq_handler (ready_for_irq_handler),
    .mret_inst             (mret_inst),
    .resume_pc             (resume_pc),
    .timer_timeout         (timer_timeout),
    .sw_irq                (sw_irq),
    .ext_irq               (ext_irq),
    .plat_irq              (plat_irq),
    .write_csr             (write_csr),
    .csr_wr_addr           (csr_wr_addr),
    .csr_wr_data           (csr_wr_data),
    .csr_rd_addr           (csr_rd_addr),
    .csr_rd_data           (csr_rd_data),
    .flush_o               (flush_o),
    .enable_design         (enable_design),
    .irq_prep              (irq_prep),
    .trap_vector           (trap_vector),
    .mepc_o                (mepc_o),
    .program_finished      (program_finished)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_rd_addr = a;
    #1;
    chk(tag, csr_rd_data, exp);
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    write_csr   = 1'b1;
    csr_wr_addr = a;
    csr_wr_data = d;
    tick();
    write_csr   = 1'b0;
  endtask

  task automatic start_run;
    control_signal = 32'h1;
    tick();
    control_signal = 32'h0;
  endtask

  task automatic do_mret;
    mret_inst = 1'b1;
    tick();
    mret_inst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while (irq_prep !== 1'b1 && w < 8) begin
      tick();
      w++;
    end
    chk(tag, 32'(irq_prep), 32'h1);
  endtask

  task automatic enter_trap(input string tag, input logic [31:0] pc);
    wait_drain({tag, "_drain"});
    resume_pc             = pc;
    ready_for_irq_handler = 1'b1;
    tick();
    ready_for_irq_handler = 1'b0;
  endtask

  // Reference: mip image from the interrupt levels.
  function automatic logic [31:0] mip_of(input logic e, input logic s, input logic t,
                                         input logic [NP-1:0] p);
    logic [31:0] m;
    m = '0;
    m[11] = e;
    m[3]  = s;
    m[7]  = t;
    for (int i = 0; i < NP; i++) m[16+i] = p[i];
    return m;
  endfunction

  // Reference: first pending source in priority order, -1 if none.
  function automatic int winner(input logic [31:0] pend);
    int order[3+NP];
    order[0] = 11;
    order[1] = 3;
    order[2] = 7;
    for (int i = 0; i < NP; i++) order[3+i] = 16 + i;
    for (int k = 0; k < 3 + NP; k++) if (pend[order[k]]) return order[k];
    return -1;
  endfunction

  initial begin
    reset = 1'b1;
    control_signal = '0; end_condition = 0; all_ready = 0; ready_for_irq_handler = 0;
    mret_inst = 0; resume_pc = '0; timer_timeout = 0; sw_irq = 0; ext_irq = 0;
    plat_irq = '0; write_csr = 0; csr_wr_addr = '0; csr_wr_data = '0; csr_rd_addr = '0;
    #25;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_enable", 32'(enable_design), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_prep", 32'(irq_prep), 32'h0);
    chk("rst_finished", 32'(program_finished), 32'h0);
    chk("rst_tvec", trap_vector, MTV_RST);
    chk("rst_mepc_o", mepc_o, 32'h0);
    chk_csr("rst_mstatus", 12'h300, 32'h0);
    chk_csr("rst_mtvec", 12'h305, MTV_RST);
    chk_csr("rst_mcause", 12'h342, 32'h0);

    // 1: timer interrupt with a 3-cycle drain
    wr_csr(12'h304, 32'h80);
    wr_csr(12'h300, 32'h8);
    chk("t1_idle_enable", 32'(enable_design), 32'h0);
    start_run();
    chk("t1_run_enable", 32'(enable_design), 32'h1);
    timer_timeout = 1'b1;
    tick();
    chk("t1_latency_prep", 32'(irq_prep), 32'h0);
    chk_csr("t1_mip", 12'h344, 32'h80);
    tick();
    resume_pc = 32'h104;
    prep_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (irq_prep === 1'b1) prep_cnt++;
      if (c == 2) ready_for_irq_handler = 1'b1;
      tick();
    end
    ready_for_irq_handler = 1'b0;
    chk("t1_prep_cycles", prep_cnt, 32'd3);
    chk("t1_prep_off", 32'(irq_prep), 32'h0);
    chk("t1_mepc_o", mepc_o, 32'h104);
    chk_csr("t1_mcause", 12'h342, 32'h8000_0007);
    chk_csr("t1_mstatus", 12'h300, 32'h80);
    chk("t1_tvec", trap_vector, MTV_RST);
    timer_timeout = 1'b0;
    tick();
    do_mret();
    chk_csr("t1_mret_mstatus", 12'h300, 32'h88);

    // 2: ext beats sw beats timer
    wr_csr(12'h304, 32'h888);
    ext_irq = 1; sw_irq = 1; timer_timeout = 1;
    enter_trap("t2_ext", 32'h200);
    chk_csr("t2_ext_mcause", 12'h342, 32'h8000_000B);
    ext_irq = 0;
    tick();
    do_mret();
    enter_trap("t2_sw", 32'h300);
    chk_csr("t2_sw_mcause", 12'h342, 32'h8000_0003);
    chk("t2_sw_mepc", mepc_o, 32'h300);
    sw_irq = 0; timer_timeout = 0;
    tick();
    do_mret();

    // 3: platform lines, vectored mtvec
    wr_csr(12'h305, 32'h1001);
`ifdef TRAP_VECTORED_MODE_EN
    exp_mtvec = 32'h1001;
    exp_tv    = 32'h1044;
`else
    exp_mtvec = 32'h1000;
    exp_tv    = 32'h1000;
`endif
    chk_csr("t3_mtvec", 12'h305, exp_mtvec);
    wr_csr(12'h304, 32'h6_0000);
    plat_irq = 4'b0110;
    enter_trap("t3_plat", 32'h400);
    chk_csr("t3_mcause", 12'h342, 32'h8000_0011);
    chk("t3_tvec", trap_vector, exp_tv);
    plat_irq = '0;
    tick();
    do_mret();

    // 5: trap entry beats CSR write to mepc; read forwarding
    wr_csr(12'h304, 32'h80);
    timer_timeout = 1'b1;
    wait_drain("t5_drain");
    write_csr = 1'b1; csr_wr_addr = 12'h341; csr_wr_data = 32'hDEAD_0000;
    resume_pc = 32'h508; ready_for_irq_handler = 1'b1;
    tick();
    write_csr = 1'b0; ready_for_irq_handler = 1'b0;
    chk("t5_mepc_override", mepc_o, 32'h508);
    timer_timeout = 1'b0;
    tick();
    do_mret();
    write_csr = 1'b1; csr_wr_addr = 12'h341; csr_wr_data = 32'h1234_5677;
    csr_rd_addr = 12'h341;
    #1;
    chk("t5_fwd", csr_rd_data, 32'h1234_5677);
    tick();
    write_csr = 1'b0;
    chk_csr("t5_mepc_align", 12'h341, 32'h1234_5674);
    write_csr = 1'b1; csr_wr_addr = 12'h344; csr_wr_data = 32'hFFFF_FFFF;
    csr_rd_addr = 12'h344;
    #1;
    chk("t5_mip_nofwd", csr_rd_data, 32'h0);
    tick();
    write_csr = 1'b0;
    chk_csr("t5_mip_ro", 12'h344, 32'h0);
    wr_csr(12'h7C0, 32'hABCD);
    chk_csr("t5_unimpl", 12'h7C0, 32'h0);
    wr_csr(12'h340, 32'hCAFE_F00D);
    chk_csr("t5_mscratch", 12'h340, 32'hCAFE_F00D);

    // 6: interrupt beats end_condition; then DONE
    timer_timeout = 1'b1;
    tick();
    end_condition = 1'b1;
    tick();
    end_condition = 1'b0;
    chk("t6_prep", 32'(irq_prep), 32'h1);
    chk("t6_not_done", 32'(program_finished), 32'h0);
    enter_trap("t6", 32'h600);
    timer_timeout = 1'b0;
    tick();
    do_mret();
    end_condition = 1'b1;
    tick();
    end_condition = 1'b0;
    chk("t6_done", 32'(program_finished), 32'h1);
    chk("t6_done_enable", 32'(enable_design), 32'h1);
    control_signal = 32'h2;
    tick();
    control_signal = 32'h0;
    chk("t6_flush", 32'(flush_o), 32'h1);
    chk_csr("t6_flush_mscratch", 12'h340, 32'h0);
    all_ready = 1'b1;
    tick();
    all_ready = 1'b0;
    chk("t6_idle_enable", 32'(enable_design), 32'h0);

    // 4: reset_request during IRQ_DRAIN
    wr_csr(12'h340, 32'h55);
    wr_csr(12'h341, 32'h44);
    wr_csr(12'h342, 32'h9);
    wr_csr(12'h305, 32'h3000);
    wr_csr(12'h304, 32'h8);
    wr_csr(12'h300, 32'h8);
    start_run();
    sw_irq = 1'b1;
    wait_drain("t4_drain");
    control_signal = 32'h2;
    tick();
    control_signal = 32'h0;
    sw_irq = 1'b0;
    chk("t4_flush", 32'(flush_o), 32'h1);
    chk("t4_prep_off", 32'(irq_prep), 32'h0);
    tick();
    tick();
    chk("t4_flush_hold", 32'(flush_o), 32'h1);
    all_ready = 1'b1;
    tick();
    all_ready = 1'b0;
    chk("t4_flush_off", 32'(flush_o), 32'h0);
    chk("t4_idle", 32'(enable_design), 32'h0);
    chk("t4_tvec", trap_vector, MTV_RST);
    chk_csr("t4_mstatus", 12'h300, 32'h0);
    chk_csr("t4_mie", 12'h304, 32'h0);
    chk_csr("t4_mtvec", 12'h305, MTV_RST);
    chk_csr("t4_mscratch", 12'h340, 32'h0);
    chk_csr("t4_mepc", 12'h341, 32'h0);
    chk_csr("t4_mcause", 12'h342, 32'h0);

    // Randomized interrupt patterns against the priority-list model
    wr_csr(12'h300, 32'h8);
    start_run();
    for (int it = 0; it < 24; it++) begin
      mie_v = $urandom & mip_of(1'b1, 1'b1, 1'b1, '1);
      e_v = 1'($urandom_range(0, 1));
      s_v = 1'($urandom_range(0, 1));
      t_v = 1'($urandom_range(0, 1));
      p_v = NP'($urandom);
      wr_csr(12'h304, mie_v);
      chk_csr("rnd_mie", 12'h304, mie_v);
      pend_v = mip_of(e_v, s_v, t_v, p_v) & mie_v;
      win = winner(pend_v);
      ext_irq = e_v; sw_irq = s_v; timer_timeout = t_v; plat_irq = p_v;
      tick();
      if (win >= 0) begin
        pc_v = $urandom;
        enter_trap("rnd_trap", pc_v);
        chk_csr("rnd_mcause", 12'h342, 32'h8000_0000 | 32'(win));
        chk("rnd_mepc", mepc_o, pc_v & 32'hFFFF_FFFC);
        chk_csr("rnd_mstatus", 12'h300, 32'h80);
        ext_irq = 0; sw_irq = 0; timer_timeout = 0; plat_irq = '0;
        tick();
        do_mret();
        chk_csr("rnd_mret_mstatus", 12'h300, 32'h88);
      end else begin
        for (int c = 0; c < 3; c++) begin
          chk("rnd_no_trap", 32'(irq_prep), 32'h0);
          tick();
        end
        ext_irq = 0; sw_irq = 0; timer_timeout = 0; plat_irq = '0;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
